// File: rtl/axi_wrr_arbiter.sv
// Weighted round-robin arbiter with a starvation guard for one shared crossbar slave port.
// An owner keeps winning while it has credit; any requester that waits STARVE_LIMIT cycles wins next.
module axi_wrr_arbiter #(
  parameter int N_REQ        = 2,
  parameter int WEIGHT_W     = 4,
  parameter int STARVE_LIMIT = 16,
  parameter int IDX_W        = $clog2(N_REQ)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_REQ-1:0]            req_i,
  input  logic                        ack_i,
  input  logic [N_REQ*WEIGHT_W-1:0]   weight_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [IDX_W-1:0]            grant_idx_o,
  output logic                        busy_o,
  output logic                        starve_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t              state_q;
  logic [N_REQ-1:0]    grant_q;
  logic [IDX_W-1:0]    idx_q;
  logic                busy_q;
  logic                starve_q;
  logic [IDX_W-1:0]    last_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [CNT_W-1:0]    wait_q [N_REQ];

  logic [IDX_W-1:0]    win_idx_d;
  logic                win_starve_d;
  logic                win_new_d;
  logic [IDX_W-1:0]    cand_d;
  logic [N_REQ-1:0]    grant_d;
  logic [WEIGHT_W-1:0] win_weight_d;
  logic [WEIGHT_W-1:0] credit_load_d;

  // Later assignments override earlier ones: round-robin, then continuation, then starvation.
  always_comb begin
    win_idx_d    = last_q;
    win_starve_d = 1'b0;
    win_new_d    = 1'b1;
    cand_d       = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_d = IDX_W'((int'(last_q) + k) % N_REQ);
      if (req_i[cand_d]) win_idx_d = cand_d;
    end
    if (req_i[last_q] && credit_q != '0) begin
      win_idx_d = last_q;
      win_new_d = 1'b0;
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i] && wait_q[i] == CNT_W'(STARVE_LIMIT)) begin
        win_idx_d    = IDX_W'(i);
        win_starve_d = 1'b1;
        win_new_d    = 1'b1;
      end
    end
  end

  assign grant_d       = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_d;
  assign win_weight_d  = weight_i[int'(win_idx_d)*WEIGHT_W +: WEIGHT_W];
  // Credit counts the owner's remaining transactions including the one in flight; each ack spends one.
  assign credit_load_d = (win_weight_d == '0) ? WEIGHT_W'(1) : win_weight_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      starve_q <= 1'b0;
      last_q   <= IDX_W'(N_REQ - 1);
      credit_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q  <= GRANTED;
            grant_q  <= grant_d;
            idx_q    <= win_idx_d;
            busy_q   <= 1'b1;
            starve_q <= win_starve_d;
            last_q   <= win_idx_d;
            if (win_new_d) credit_q <= credit_load_d;
          end
        end
        GRANTED: begin
          starve_q <= 1'b0;
          if (ack_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            if (credit_q != '0) credit_q <= credit_q - 1'b1;
          end
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wait
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          wait_q[gi] <= '0;
        end else if (grant_q[gi] || !req_i[gi]) begin
          wait_q[gi] <= '0;
        end else if (wait_q[gi] != CNT_W'(STARVE_LIMIT)) begin
          wait_q[gi] <= wait_q[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign busy_o      = busy_q;
  assign starve_o    = starve_q;

endmodule

// File: tb/tb_axi_wrr_arbiter.sv
// Directed bench for axi_wrr_arbiter: table of grant transactions plus hand sequences
// for starvation, held grants and asynchronous reset.
module tb_axi_wrr_arbiter;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [1:0] req;
  logic       ack;
  logic [7:0] weight;
  logic [1:0] grant_m, grant_s;
  logic       idx_m, idx_s, busy_m, busy_s, starve_m, starve_s;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_wrr_arbiter #(.N_REQ(2), .WEIGHT_W(4), .STARVE_LIMIT(16)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .req_i(req), .ack_i(ack), .weight_i(weight),
    .grant_o(grant_m), .grant_idx_o(idx_m), .busy_o(busy_m), .starve_o(starve_m)
  );

  axi_wrr_arbiter #(.N_REQ(2), .WEIGHT_W(4), .STARVE_LIMIT(4)) u_dut_s (
    .aclk(aclk), .aresetn(aresetn), .req_i(req), .ack_i(ack), .weight_i(weight),
    .grant_o(grant_s), .grant_idx_o(idx_s), .busy_o(busy_s), .starve_o(starve_s)
  );

  typedef struct {
    bit         do_reset;
    logic [1:0] req;
    logic [7:0] weight;
    int         hold;
    int         exp_idx;
    bit         exp_starve;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    req     = 2'b00;
    ack     = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
    chk("reset_grant", {30'd0, grant_m}, 0);
    chk("reset_busy", {31'd0, busy_m}, 0);
    chk("reset_idx", {31'd0, idx_m}, 0);
    chk("reset_starve", {31'd0, starve_m}, 0);
  endtask

  // One grant: appears one cycle after arbitration, held for 'hold' cycles, then acked.
  task automatic txn(input bit s, input int exp_idx, input bit exp_st, input int hold);
    logic [1:0] g;
    logic       ix, b, st;
    tick();
    g = s ? grant_s : grant_m; ix = s ? idx_s : idx_m;
    b = s ? busy_s : busy_m;   st = s ? starve_s : starve_m;
    chk("grant", {30'd0, g}, 32'd1 << exp_idx);
    chk("grant_idx", {31'd0, ix}, exp_idx);
    chk("busy", {31'd0, b}, 1);
    chk("starve", {31'd0, st}, {31'd0, exp_st});
    $display("txn: grant=%b idx=%0d starve=%0b (expected idx %0d)", g, ix, st, exp_idx);
    for (int k = 1; k < hold; k++) begin
      tick();
      g = s ? grant_s : grant_m;
      st = s ? starve_s : starve_m;
      chk("grant_held", {30'd0, g}, 32'd1 << exp_idx);
      chk("starve_pulse", {31'd0, st}, 0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    g = s ? grant_s : grant_m;
    b = s ? busy_s : busy_m;
    chk("idle_grant", {30'd0, g}, 0);
    chk("idle_busy", {31'd0, b}, 0);
  endtask

  initial begin
    // Equal weights alternate.
    vecs[0]  = '{1'b1, 2'b11, 8'h11, 2, 0, 1'b0};
    vecs[1]  = '{1'b0, 2'b11, 8'h11, 2, 1, 1'b0};
    vecs[2]  = '{1'b0, 2'b11, 8'h11, 2, 0, 1'b0};
    vecs[3]  = '{1'b0, 2'b11, 8'h11, 2, 1, 1'b0};
    // w0=3, w1=1.
    vecs[4]  = '{1'b1, 2'b11, 8'h13, 2, 0, 1'b0};
    vecs[5]  = '{1'b0, 2'b11, 8'h13, 2, 0, 1'b0};
    vecs[6]  = '{1'b0, 2'b11, 8'h13, 2, 0, 1'b0};
    vecs[7]  = '{1'b0, 2'b11, 8'h13, 2, 1, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 8'h13, 2, 0, 1'b0};
    vecs[9]  = '{1'b0, 2'b11, 8'h13, 2, 0, 1'b0};
    vecs[10] = '{1'b0, 2'b11, 8'h13, 2, 0, 1'b0};
    vecs[11] = '{1'b0, 2'b11, 8'h13, 2, 1, 1'b0};
    // Weight 0 on the sole requester.
    vecs[12] = '{1'b1, 2'b01, 8'h10, 2, 0, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 8'h10, 2, 0, 1'b0};
    vecs[14] = '{1'b0, 2'b01, 8'h10, 2, 0, 1'b0};

    aresetn = 1'b0;
    req     = 2'b00;
    ack     = 1'b0;
    weight  = 8'h11;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_reset) do_reset();
      weight = vecs[i].weight;
      req    = vecs[i].req;
      txn(1'b0, vecs[i].exp_idx, vecs[i].exp_starve, vecs[i].hold);
    end

    // Starvation: STARVE_LIMIT=4 instance overrides the heavy owner; default instance continues.
    do_reset();
    weight = 8'h1F;
    req    = 2'b11;
    txn(1'b1, 0, 1'b0, 5);
    tick();
    chk("starve_grant", {30'd0, grant_s}, 2);
    chk("starve_flag", {31'd0, starve_s}, 1);
    chk("nostarve_grant", {30'd0, grant_m}, 1);
    chk("nostarve_flag", {31'd0, starve_m}, 0);
    $display("starve: limit4 grant=%b starve=%0b, limit16 grant=%b starve=%0b",
             grant_s, starve_s, grant_m, starve_m);
    tick();
    chk("starve_one_cycle", {31'd0, starve_s}, 0);
    chk("starve_grant_held", {30'd0, grant_s}, 2);

    // Grant held after request drops; ack in IDLE ignored.
    do_reset();
    weight = 8'h11;
    req    = 2'b10;
    tick();
    chk("m1_grant", {30'd0, grant_m}, 2);
    req = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("m1_held", {30'd0, grant_m}, 2);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("m1_release", {30'd0, grant_m}, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_grant", {30'd0, grant_m}, 0);
    chk("idle_ack_busy", {31'd0, busy_m}, 0);
    chk("idle_idx_hold", {31'd0, idx_m}, 1);
    tick();
    chk("idle_ack_still", {30'd0, grant_m}, 0);
    $display("hold: grant=%b busy=%0b idx=%0d after idle ack", grant_m, busy_m, idx_m);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 2'b10;
    tick();
    chk("pre_reset_grant", {30'd0, grant_m}, 2);
    #1 aresetn = 1'b0;
    #1;
    chk("async_clear_grant", {30'd0, grant_m}, 0);
    chk("async_clear_busy", {31'd0, busy_m}, 0);
    req = 2'b11;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    chk("post_reset_idle", {30'd0, grant_m}, 0);
    tick();
    chk("post_reset_grant", {30'd0, grant_m}, 1);
    $display("reset: post-release grant=%b", grant_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
